// File: rtl/bcd_countdown_timer_if.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer_if
// Bundles the control and status signals of the BCD countdown timer.
//
// Parameter:
//   DIGITS      number of BCD digits carried on load_value / count
//
// Signals:
//   enable      count permission from the access controller
//   reconfig    synchronous reload request
//   load_value  BCD value applied on reconfig
//   count       current BCD count towards the seven-segment decoders
//   tick        one-cycle pulse on each count step
//   TimeOut     one-cycle pulse when the count reaches zero
//   busy        high while the timer is running
//   load_err    one-cycle pulse when load_value is rejected
//
// Modports:
//   master      controller side (drives enable/reconfig/load_value)
//   slave       timer side (drives count and status)
// ---------------------------------------------------------------------------
interface bcd_countdown_timer_if #(
    parameter int DIGITS = 3
);
    logic                  enable;
    logic                  reconfig;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   count;
    logic                  tick;
    logic                  TimeOut;
    logic                  busy;
    logic                  load_err;

    modport master (
        output enable, reconfig, load_value,
        input  count, tick, TimeOut, busy, load_err
    );

    modport slave (
        input  enable, reconfig, load_value,
        output count, tick, TimeOut, busy, load_err
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
// Prescaled multi-digit BCD down-counter. Every TICK_CYCLES enabled clocks
// the count steps down by one (BCD with borrow); reaching zero raises a
// one-cycle TimeOut pulse. A reconfig request reloads the count at any time.
//
// Parameters:
//   TICK_CYCLES  enabled clock cycles per count step (>= 2)
//   DIGITS       number of BCD digits (1..8)
//   START_BCD    reset / fallback reload value, every nibble <= 9
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   bus          slave modport of bcd_countdown_timer_if
//
// Build option:
//   AUTO_RELOAD_EN  when defined, expiry reloads the last accepted load value
//                   and keeps running (periodic timer) instead of entering
//                   DONE.
// ---------------------------------------------------------------------------
module bcd_countdown_timer #(
    parameter int                  TICK_CYCLES = 50000000,
    parameter int                  DIGITS      = 3,
    parameter logic [4*DIGITS-1:0] START_BCD   = (4*DIGITS)'(12'h120)
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_countdown_timer_if.slave   bus
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TERMINAL = PW'(TICK_CYCLES - 1);
    localparam logic [W-1:0]  ONE      = W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [W-1:0]    count_r;
    logic [W-1:0]    last_load;
    logic            tick_r;
    logic            timeout_r;
    logic            busy_r;
    logic            load_err_r;

    // Ripple a borrow up from the ones digit: a zero digit becomes 9 and
    // passes the borrow on, the first non-zero digit absorbs it.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_valid_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Single state machine: reconfig overrides everything in any state, so
    // a reload always lands in IDLE with a clean prescaler and no pulses.
    // A count of 1 at the terminal prescaler value is the expiry step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prescaler  <= '0;
            count_r    <= START_BCD;
            last_load  <= START_BCD;
            tick_r     <= 1'b0;
            timeout_r  <= 1'b0;
            busy_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            tick_r     <= 1'b0;
            timeout_r  <= 1'b0;
            load_err_r <= 1'b0;

            if (bus.reconfig) begin
                state     <= IDLE;
                prescaler <= '0;
                busy_r    <= 1'b0;
                if (is_valid_bcd(bus.load_value)) begin
                    count_r   <= bus.load_value;
                    last_load <= bus.load_value;
                end else begin
                    count_r    <= START_BCD;
                    load_err_r <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.enable) begin
                            prescaler <= '0;
                            if (count_r == '0) begin
                                timeout_r <= 1'b1;
`ifdef AUTO_RELOAD_EN
                                count_r <= last_load;
                                state   <= RUN;
                                busy_r  <= 1'b1;
`else
                                state   <= DONE;
                                busy_r  <= 1'b0;
`endif
                            end else begin
                                state  <= RUN;
                                busy_r <= 1'b1;
                            end
                        end
                    end

                    RUN: begin
                        busy_r <= 1'b1;
                        if (bus.enable) begin
                            if (prescaler == TERMINAL) begin
                                prescaler <= '0;
                                tick_r    <= 1'b1;
                                if (count_r == ONE || count_r == '0) begin
                                    timeout_r <= 1'b1;
`ifdef AUTO_RELOAD_EN
                                    count_r <= last_load;
`else
                                    count_r <= '0;
                                    state   <= DONE;
                                    busy_r  <= 1'b0;
`endif
                                end else begin
                                    count_r <= bcd_dec(count_r);
                                end
                            end else begin
                                prescaler <= prescaler + 1'b1;
                            end
                        end
                    end

                    DONE: begin
                        busy_r  <= 1'b0;
                        count_r <= '0;
                    end

                    default: begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count    = count_r;
    assign bus.tick     = tick_r;
    assign bus.TimeOut  = timeout_r;
    assign bus.busy     = busy_r;
    assign bus.load_err = load_err_r;

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised successor to the fixed 120-count timer. It combines a prescaler tick generator with a multi-digit BCD down-counter.
- Counts down from a runtime-loadable BCD value, one step per TICK_CYCLES enabled clocks.
- Raises TimeOut when the count reaches zero.
- Sits between the access controller (enable, reconfig, load value) and the seven-segment decoders (BCD digits).

Parameters:
- TICK_CYCLES, 50000000, enabled clock cycles per count step (>=2).
- DIGITS, 3, number of BCD digits (1..8).
- START_BCD, 12'h120, default reload value. 4*DIGITS bits, every nibble <=9.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  count permission. Level-sensitive; low freezes prescaler and count.
- reconfig  in  1  synchronous reload request, single-cycle or held.
- load_value  in  4*DIGITS  BCD value applied on reconfig.
- count  out  4*DIGITS  current BCD count. Digit 0 is bits [3:0] (ones).
- tick  out  1  one-cycle pulse on each count step.
- TimeOut  out  1  one-cycle pulse when the count reaches zero.
- busy  out  1  high while in RUN.
- load_err  out  1  one-cycle pulse when load_value is rejected.

Behaviour:
- Reset (rst=0, async): state=IDLE, count=START_BCD, prescaler=0. tick, TimeOut, busy and load_err all 0.
- All outputs are registered. tick, TimeOut and load_err are high for exactly one cycle per event.

States:
- IDLE: count holds the loaded value. If enable=1, the next state is RUN. If count==0 at that point, the next state is DONE instead, with a TimeOut pulse on the same edge.
- RUN: busy=1. When enable=1, the prescaler increments. At prescaler==TICK_CYCLES-1, on the same edge:
  - prescaler clears to 0, tick=1, count decrements.
  - If the old count==1, count becomes 0, TimeOut=1 and the next state is DONE.
  - When enable=0, prescaler and count hold and the state stays RUN.
- DONE: count holds 0 and busy=0. The block stays in DONE until reconfig, regardless of enable.

Timing and arithmetic:
- The first tick occurs TICK_CYCLES enabled cycles after RUN is entered.
- Expiry occurs N*TICK_CYCLES enabled cycles after RUN entry, where N is the loaded value.
- Decrement is pure BCD with borrow: a digit of 0 becomes 9 and borrows from the next digit (e.g. 0x100 -> 0x099).
- No wrap below zero.

reconfig (highest priority, any state, overrides tick and enable that cycle):
- If every nibble of load_value is <=9: count=load_value.
- Otherwise: count=START_BCD and load_err=1.
- In both cases prescaler=0, state=IDLE, and tick/TimeOut are suppressed that cycle.
- While reconfig is held, the block keeps reloading.

Reset mid-count aborts immediately to the reset values. No pending pulse survives.

Optional Feature:
- Macro: AUTO_RELOAD_EN.
- Defined: on expiry, TimeOut pulses, count reloads the last accepted load value (START_BCD after reset) on the same edge, prescaler=0, and the state stays RUN (periodic timer). A loaded value of 0 gives a TimeOut pulse every TICK_CYCLES enabled cycles.
- Undefined: the block enters DONE and holds as described above.

Test Plan (TICK_CYCLES=4, DIGITS=3, START_BCD=12'h120):
- Assert rst=0 mid-run, then release -> count=0x120, tick=TimeOut=busy=load_err=0, state IDLE.
- enable=1 held from IDLE -> busy=1 next cycle; count=0x119 four cycles later; 0x100->0x099 seen; TimeOut single pulse exactly 480 cycles after RUN entry; count stays 0x000, busy=0.
- During RUN drop enable for 10 cycles -> count and tick frozen; expiry delayed by exactly 10 cycles.
- reconfig with load_value=0x005 during RUN -> IDLE, count=0x005, no tick that cycle; enable -> TimeOut 20 enabled cycles after RUN entry. load_value=0x000 -> TimeOut on the first enabled edge.
- reconfig with load_value=0x0A3 -> load_err pulse, count=0x120. Simultaneous reconfig and terminal prescaler -> no tick or decrement.
- With AUTO_RELOAD_EN and load 0x002 -> TimeOut every 8 cycles; count sequence 2,1,2,1; busy stays 1.
